// File: rtl/seq_divider_8bit_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package seq_divider_8bit_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_8bit_if.sv
// Board-facing bundle: command strobe, switches, six hex digits and status LEDs.
interface seq_divider_8bit_if;

  logic       i_key1;
  logic [9:0] i_sw;
  logic [6:0] o_hex0;
  logic [6:0] o_hex1;
  logic [6:0] o_hex2;
  logic [6:0] o_hex3;
  logic [6:0] o_hex4;
  logic [6:0] o_hex5;
  logic [2:0] o_ledr;

  modport slave (
    input  i_key1, i_sw,
    output o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_ledr
  );

  modport master (
    output i_key1, i_sw,
    input  o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_ledr
  );

endinterface

// File: rtl/hex_ssd.sv
// Nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_ssd (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_nib)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seq_divider_8bit_div_core.sv
// Restoring divide datapath, one quotient bit per clock; WIDTH cycles busy per start.
// With DIV_ZERO_TRAP_EN a zero divisor presets Q=all-ones, R=dividend without iterating.
module div_core
  import seq_divider_8bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_qbit;

  // r_work starts as the dividend and fills with quotient bits from the right.
  // The difference is only taken when w_shift >= divisor, so it always fits WIDTH bits.
  always_comb begin
    w_shift = {r_rem, r_work[WIDTH-1]};
    w_qbit  = (w_shift >= {1'b0, r_dvs});
    w_diff  = w_shift[WIDTH-1:0] - r_dvs;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_work <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
    end else if (i_start) begin
`ifdef DIV_ZERO_TRAP_EN
      if (i_divisor == '0) begin
        r_busy <= 1'b0;
        r_work <= '1;
        r_rem  <= i_dividend;
      end else
`endif
      begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(WIDTH - 1);
        r_work <= i_dividend;
        r_rem  <= '0;
        r_dvs  <= i_divisor;
      end
    end else if (r_busy) begin
      r_work <= {r_work[WIDTH-2:0], w_qbit};
      r_rem  <= w_qbit ? w_diff : w_shift[WIDTH-1:0];
      r_cnt  <= r_cnt - 1'b1;
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_busy && (r_cnt == '0);
  assign o_quotient  = r_work;
  assign o_remainder = r_rem;

endmodule

// File: rtl/seq_divider_8bit.sv
// Top: KEY[1] synchroniser + edge detect, operand registers, IDLE/RUN/DONE control, hex display mux.
// Optional DIV_ZERO_TRAP_EN: a start with B==0 goes straight to DONE and raises LEDR[2].
module seq_divider_8bit
  import seq_divider_8bit_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              CLOCK_50,
  input  logic              i_rst,
  seq_divider_8bit_if.slave bus
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_key_prev;
  logic                   w_cmd;
  state_t                 r_state;
  state_t                 w_next;
  logic                   w_start;
  logic                   w_load;
  logic                   w_trap;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;
  logic [WIDTH-1:0]       w_res;
  logic                   w_core_busy;
  logic                   w_core_done;

  assign w_cmd = r_sync[SYNC_STAGES-1] & ~r_key_prev;

  always_ff @(posedge CLOCK_50 or posedge i_rst) begin
    if (i_rst) begin
      r_sync     <= '0;
      r_key_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.i_key1};
      r_key_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Commands are only decoded outside RUN, so a strobe mid-divide is dropped.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_cmd) begin
          if (bus.i_sw[9]) begin
            w_start = 1'b1;
            w_next  = w_trap ? ST_DONE : ST_RUN;
          end else begin
            w_load = 1'b1;
            w_next = ST_IDLE;
          end
        end
      end
      ST_RUN:  if (w_core_done) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge i_rst) begin
    if (i_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_load) begin
      if (bus.i_sw[8]) r_b <= bus.i_sw[WIDTH-1:0];
      else             r_a <= bus.i_sw[WIDTH-1:0];
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  logic r_dz;
  assign w_trap = (r_b == '0);
  always_ff @(posedge CLOCK_50 or posedge i_rst) begin
    if (i_rst)                  r_dz <= 1'b0;
    else if (w_load || w_start) r_dz <= w_start & w_trap;
  end
  assign bus.o_ledr[2] = r_dz;
`else
  assign w_trap        = 1'b0;
  assign bus.o_ledr[2] = 1'b0;
`endif

  div_core #(.WIDTH(WIDTH)) u_core (
    .i_clk       (CLOCK_50),
    .i_rst       (i_rst),
    .i_start     (w_start),
    .i_dividend  (r_a),
    .i_divisor   (r_b),
    .o_busy      (w_core_busy),
    .o_done      (w_core_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign bus.o_ledr[0] = w_core_busy;
  assign bus.o_ledr[1] = (r_state == ST_DONE);

  // Result stays in the core after a load but is only shown in DONE.
  assign w_res = (r_state == ST_DONE) ? (bus.i_sw[8] ? w_rem : w_quo) : '0;

  hex_ssd u_hex0 (.i_nib(r_a[3:0]),   .o_seg(bus.o_hex0));
  hex_ssd u_hex1 (.i_nib(r_a[7:4]),   .o_seg(bus.o_hex1));
  hex_ssd u_hex2 (.i_nib(r_b[3:0]),   .o_seg(bus.o_hex2));
  hex_ssd u_hex3 (.i_nib(r_b[7:4]),   .o_seg(bus.o_hex3));
  hex_ssd u_hex4 (.i_nib(w_res[3:0]), .o_seg(bus.o_hex4));
  hex_ssd u_hex5 (.i_nib(w_res[7:4]), .o_seg(bus.o_hex5));

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench: vector table, hand-written corner sequences and random operands vs. an arithmetic model.
module tb_seq_divider_8bit;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #10 clk = ~clk;

  seq_divider_8bit_if dif();

  seq_divider_8bit dut (
    .CLOCK_50 (clk),
    .i_rst    (rst),
    .bus      (dif.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] seg2(input logic [7:0] v);
    return {18'd0, seg(v[7:4]), seg(v[3:0])};
  endfunction

  function automatic logic [31:0] hex_a();
    return {18'd0, dif.o_hex1, dif.o_hex0};
  endfunction
  function automatic logic [31:0] hex_b();
    return {18'd0, dif.o_hex3, dif.o_hex2};
  endfunction
  function automatic logic [31:0] hex_r();
    return {18'd0, dif.o_hex5, dif.o_hex4};
  endfunction

  // Reference: plain integer division; zero divisor gives all-ones quotient and remainder A.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {8'hFF, a};
    return {8'(a / b), 8'(a % b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [9:0] sw);
    dif.i_sw   = sw;
    dif.i_key1 = 1'b1;
    tick(4);
    dif.i_key1 = 1'b0;
    tick(3);
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r);
    int busy_n    = 0;
    bit done_seen = 1'b0;
    int exp_busy  = 8;
    int exp_dz    = 0;
`ifdef DIV_ZERO_TRAP_EN
    if (b == 8'd0) begin
      exp_busy = 0;
      exp_dz   = 1;
    end
`endif
    strobe({2'b00, a});
    check("ledr_after_load", 32'(dif.o_ledr), 32'd0);
    strobe({2'b01, b});
    check("hex_a", hex_a(), seg2(a));
    check("hex_b", hex_b(), seg2(b));
    dif.i_sw   = 10'h200;
    dif.i_key1 = 1'b1;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge clk);
      if (dif.o_ledr[0]) busy_n++;
      if (dif.o_ledr[1]) done_seen = 1'b1;
    end
    dif.i_key1 = 1'b0;
    check("busy_cycles", 32'(busy_n), 32'(exp_busy));
    check("done_seen", 32'(done_seen), 32'd1);
    check("quotient", hex_r(), seg2(q));
    dif.i_sw[8] = 1'b1;
    #1;
    check("remainder", hex_r(), seg2(r));
    check("div_zero_led", 32'(dif.o_ledr[2]), 32'(exp_dz));
    check("a_kept", hex_a(), seg2(a));
    tick(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    bit prev_busy;
    logic [7:0]  ra, rb;
    logic [15:0] m;

    vecs[0] = '{8'h64, 8'h07, 8'h0E, 8'h02};
    vecs[1] = '{8'hFF, 8'h01, 8'hFF, 8'h00};
    vecs[2] = '{8'h05, 8'h09, 8'h00, 8'h05};
    vecs[3] = '{8'h20, 8'h03, 8'h0A, 8'h02};
    vecs[4] = '{8'hFE, 8'h10, 8'h0F, 8'h0E};
    vecs[5] = '{8'hFF, 8'hFF, 8'h01, 8'h00};
    vecs[6] = '{8'h80, 8'h81, 8'h00, 8'h80};
    vecs[7] = '{8'hC8, 8'h0A, 8'h14, 8'h00};
    vecs[8] = '{8'h5A, 8'h00, 8'hFF, 8'h5A};
    vecs[9] = '{8'h00, 8'h05, 8'h00, 8'h00};

    rst        = 1'b1;
    dif.i_key1 = 1'b0;
    dif.i_sw   = 10'h000;
    tick(3);
    #1;
    check("rst_hex_a", hex_a(), seg2(8'h00));
    check("rst_hex_b", hex_b(), seg2(8'h00));
    check("rst_hex_r", hex_r(), seg2(8'h00));
    check("rst_ledr", 32'(dif.o_ledr), 32'd0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 10; i++) run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

    // Load strobe arriving mid-RUN must be ignored.
    strobe(10'h064);
    strobe(10'h107);
    dif.i_sw   = 10'h200;
    dif.i_key1 = 1'b1;
    for (int c = 0; c < 20 && !dif.o_ledr[0]; c++) @(negedge clk);
    check("run_started", 32'(dif.o_ledr[0]), 32'd1);
    dif.i_key1 = 1'b0;
    tick(1);
    dif.i_sw   = 10'h033;
    dif.i_key1 = 1'b1;
    for (int c = 0; c < 30 && !dif.o_ledr[1]; c++) @(negedge clk);
    dif.i_key1 = 1'b0;
    check("midrun_done", 32'(dif.o_ledr[1]), 32'd1);
    check("midrun_a", hex_a(), seg2(8'h64));
    check("midrun_b", hex_b(), seg2(8'h07));
    check("midrun_q", hex_r(), seg2(8'h0E));
    tick(4);

    // A start strobe held high for 50 cycles must launch exactly one divide.
    strobe(10'h064);
    dif.i_sw   = 10'h200;
    dif.i_key1 = 1'b1;
    rises      = 0;
    prev_busy  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (dif.o_ledr[0] && !prev_busy) rises++;
      prev_busy = dif.o_ledr[0];
    end
    dif.i_key1 = 1'b0;
    check("held_key_starts", 32'(rises), 32'd1);
    check("held_key_done", 32'(dif.o_ledr[1]), 32'd1);
    check("held_key_q", hex_r(), seg2(8'h0E));
    tick(3);

    // Reset in the middle of RUN clears everything immediately.
    strobe(10'h0C8);
    strobe(10'h10A);
    dif.i_sw   = 10'h200;
    dif.i_key1 = 1'b1;
    for (int c = 0; c < 20 && !dif.o_ledr[0]; c++) @(negedge clk);
    dif.i_key1 = 1'b0;
    tick(3);
    rst = 1'b1;
    #1;
    check("midrst_hex_a", hex_a(), seg2(8'h00));
    check("midrst_hex_b", hex_b(), seg2(8'h00));
    check("midrst_hex_r", hex_r(), seg2(8'h00));
    check("midrst_ledr", 32'(dif.o_ledr), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    run_div(8'hC8, 8'h0A, 8'h14, 8'h00);

    // Load from DONE returns to IDLE and hides the result.
    strobe(10'h020);
    check("done_load_ledr", 32'(dif.o_ledr), 32'd0);
    check("done_load_hidden", hex_r(), seg2(8'h00));
    check("done_load_a", hex_a(), seg2(8'h20));
    run_div(8'h20, 8'h03, 8'h0A, 8'h02);

    // Strobe during reset has no effect.
    rst        = 1'b1;
    dif.i_sw   = 10'h077;
    dif.i_key1 = 1'b1;
    tick(4);
    dif.i_key1 = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    check("rst_wins_a", hex_a(), seg2(8'h00));
    check("rst_wins_ledr", 32'(dif.o_ledr), 32'd0);

    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      m  = model(ra, rb);
      run_div(ra, rb, m[15:8], m[7:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
